// File: rtl/time_pkg.sv
// time_pkg: shared field limits, field-select encoding, FSM states and step helper
package time_pkg;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  typedef enum logic [2:0] {F_NONE, F_MS, F_SEC, F_MIN, F_HR} field_e;
  typedef enum logic [1:0] {IDLE, FIRST, DELAY, REPEAT} state_e;
  function automatic field_e pick_field(input logic ms, input logic s, input logic mn, input logic hr);
    return ms ? F_MS : s ? F_SEC : mn ? F_MIN : hr ? F_HR : F_NONE;
  endfunction
  function automatic int unsigned wrap_step(input int unsigned v, input int unsigned max, input logic up);
    return up ? (v >= max ? 32'd0 : v + 32'd1) : (v == 32'd0 ? max : v - 32'd1);
  endfunction
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-flop synchroniser with rising-edge pulse, blind to presses held across reset
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic pulse
);
  logic s1, s2, s2_d, primed, armed;
  // synchronise, delay for edge detect, and arm only after the button is seen released post-reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s2_d <= 1'b0;
      primed <= 1'b0;
      armed <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s2_d <= s2;
      primed <= 1'b1;
      armed <= armed | (primed & ~s1 & ~s2);
    end
  assign level = s2 & armed;
  assign pulse = s2 & ~s2_d & armed;
endmodule

// File: rtl/time_entry_ctrl.sv
// time_entry_ctrl: button-driven time field editor with auto-repeat and clear
module time_entry_ctrl
  import time_pkg::*;
#(
  parameter int unsigned MS_MAX = 999,
  parameter int unsigned HR_MAX = 23,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_sw,
  input  logic s_sw,
  input  logic min_sw,
  input  logic hr_sw,
  input  logic toggle,
  input  logic inc_btn,
  input  logic dec_btn,
  input  logic clr_btn,
  output logic [$clog2(MS_MAX+1)-1:0] ms_o,
  output logic [5:0] sec_o,
  output logic [5:0] min_o,
  output logic [$clog2(HR_MAX+1)-1:0] hr_o,
  output logic load_o
);
  localparam int unsigned MW = $clog2(MS_MAX + 1);
  localparam int unsigned HW = $clog2(HR_MAX + 1);
  localparam int unsigned RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW = $clog2(RMAX + 1);
  logic inc_l, inc_p, dec_l, dec_p, clr_l, clr_p;
  logic abort, start, dir, step, clr_go, up;
  logic [CW-1:0] cnt;
  state_e state;
  field_e fsel;
  btn_sync_edge u_inc (.clk(clk), .rst(rst), .btn(inc_btn), .level(inc_l), .pulse(inc_p));
  btn_sync_edge u_dec (.clk(clk), .rst(rst), .btn(dec_btn), .level(dec_l), .pulse(dec_p));
  btn_sync_edge u_clr (.clk(clk), .rst(rst), .btn(clr_btn), .level(clr_l), .pulse(clr_p));
  // decode active field, press start, hold abort and step timing; presses during a held clear are ignored
  always_comb begin
    fsel = pick_field(ms_sw, s_sw, min_sw, hr_sw);
    abort = toggle | (up ? (~inc_l | dec_l) : (~dec_l | inc_l));
    start = ~toggle & ~clr_l & ((inc_p & ~dec_l) | (dec_p & ~inc_l));
    dir = state == IDLE ? inc_p : up;
    step = state == IDLE ? start :
           state == DELAY ? ~abort & (cnt == CW'(REPEAT_DELAY - 1)) :
           state == REPEAT ? ~abort & (cnt == CW'(REPEAT_PERIOD - 1)) : 1'b0;
    clr_go = clr_p & ~toggle;
  end
  // press/hold state machine; the first step is taken on the edge that enters FIRST
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      up <= 1'b0;
    end else if (clr_go) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= FIRST;
          up <= inc_p;
        end
        FIRST: begin
          state <= abort ? IDLE : DELAY;
          cnt <= '0;
        end
        default: if (abort) begin
          state <= IDLE;
          cnt <= '0;
        end else if (step) begin
          state <= REPEAT;
          cnt <= '0;
        end else cnt <= cnt + CW'(1);
      endcase
    end
  // field registers with wrap-around steps, clear overriding any same-cycle step
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ms_o <= '0;
      sec_o <= '0;
      min_o <= '0;
      hr_o <= '0;
      load_o <= 1'b0;
    end else begin
      load_o <= clr_go | (step & (fsel != F_NONE));
      if (clr_go) begin
        ms_o <= '0;
        sec_o <= '0;
        min_o <= '0;
        hr_o <= '0;
      end else if (step) begin
        case (fsel)
          F_MS: ms_o <= MW'(wrap_step(32'(ms_o), MS_MAX, dir));
          F_SEC: sec_o <= 6'(wrap_step(32'(sec_o), SEC_MAX, dir));
          F_MIN: min_o <= 6'(wrap_step(32'(min_o), MIN_MAX, dir));
          F_HR: hr_o <= HW'(wrap_step(32'(hr_o), HR_MAX, dir));
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_time_entry_ctrl.sv
// tb_time_entry_ctrl: randomized and directed checks against a press-level reference model
module tb_time_entry_ctrl;
  localparam int D = 8;
  localparam int P = 4;
  logic clk = 0, rst = 1;
  logic ms_sw = 0, s_sw = 0, min_sw = 0, hr_sw = 0, toggle = 0;
  logic inc_btn = 0, dec_btn = 0, clr_btn = 0;
  logic [9:0] ms_o;
  logic [5:0] sec_o, min_o;
  logic [4:0] hr_o;
  logic [3:0] ms12_unused_hr;
  logic load_o;
  logic [9:0] ms12;
  logic [5:0] sec12, min12;
  logic load12;
  int checks = 0, failures = 0;
  int m_ms, m_sec, m_min, m_hr, m_hr12;

  time_entry_ctrl #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
    .clk(clk), .rst(rst), .ms_sw(ms_sw), .s_sw(s_sw), .min_sw(min_sw), .hr_sw(hr_sw),
    .toggle(toggle), .inc_btn(inc_btn), .dec_btn(dec_btn), .clr_btn(clr_btn),
    .ms_o(ms_o), .sec_o(sec_o), .min_o(min_o), .hr_o(hr_o), .load_o(load_o));
  time_entry_ctrl #(.HR_MAX(11), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut12 (
    .clk(clk), .rst(rst), .ms_sw(ms_sw), .s_sw(s_sw), .min_sw(min_sw), .hr_sw(hr_sw),
    .toggle(toggle), .inc_btn(inc_btn), .dec_btn(dec_btn), .clr_btn(clr_btn),
    .ms_o(ms12), .sec_o(sec12), .min_o(min12), .hr_o(ms12_unused_hr), .load_o(load12));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int wrapn(int v, int mx, bit up, int n);
    for (int k = 0; k < n; k++) v = up ? (v == mx ? 0 : v + 1) : (v == 0 ? mx : v - 1);
    return v;
  endfunction

  // steps in one hold of h sampled cycles: one at press, one after D+1 more cycles, then every P
  function automatic int steps_for(int h);
    return 1 + ((h - 1 >= D + 1) ? (h - 1 - (D + 1)) / P + 1 : 0);
  endfunction

  function automatic logic [63:0] step_mask(int h);
    logic [63:0] m = '0;
    m[2] = 1'b1;
    for (int o = D + 1; o <= h - 1; o += P) m[2 + o] = 1'b1;
    return m;
  endfunction

  function automatic bit any_sw();
    return ms_sw | s_sw | min_sw | hr_sw;
  endfunction

  task automatic model_step(input bit up, input int n);
    if (ms_sw) m_ms = wrapn(m_ms, 999, up, n);
    else if (s_sw) m_sec = wrapn(m_sec, 59, up, n);
    else if (min_sw) m_min = wrapn(m_min, 59, up, n);
    else if (hr_sw) begin
      m_hr = wrapn(m_hr, 23, up, n);
      m_hr12 = wrapn(m_hr12, 11, up, n);
    end
  endtask

  task automatic model_zero();
    m_ms = 0; m_sec = 0; m_min = 0; m_hr = 0; m_hr12 = 0;
  endtask

  function automatic logic [30:0] act();
    return {ms_o, sec_o, min_o, hr_o, ms12_unused_hr};
  endfunction

  function automatic logic [30:0] expv();
    return {m_ms[9:0], m_sec[5:0], m_min[5:0], m_hr[4:0], m_hr12[3:0]};
  endfunction

  task automatic set_sw(input logic [3:0] s);
    {ms_sw, s_sw, min_sw, hr_sw} = s;
  endtask

  // hold one button for h sampled cycles, record which post-edge samples showed load_o
  task automatic press(input bit up, input int h, output int loads, output logic [63:0] mask);
    loads = 0;
    mask = '0;
    if (up) inc_btn = 1; else dec_btn = 1;
    for (int i = 0; i < h + 10; i++) begin
      if (i == h) begin inc_btn = 0; dec_btn = 0; end
      cyc();
      if (load_o) begin loads++; mask[i] = 1'b1; end
    end
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    checks++; if (act() !== 31'd0) begin failures++; $display("FAIL reset_fields got=%h exp=0", act()); end
    checks++; if (load_o !== 1'b0) begin failures++; $display("FAIL reset_load got=%b exp=0", load_o); end
    rst = 0;
    repeat (4) cyc();
    model_zero();
    checks++; if (act() !== expv()) begin failures++; $display("FAIL post_reset got=%h exp=%h", act(), expv()); end
  endtask

  task automatic test_sec_wrap();
    int loads;
    logic [63:0] mask;
    set_sw(4'b0100);
    press(0, 1, loads, mask);
    model_step(0, 1);
    checks++; if (sec_o !== 6'd59) begin failures++; $display("FAIL sec_dec_wrap got=%0d exp=59", sec_o); end
    inc_btn = 1;
    cyc();
    cyc();
    checks++; if (sec_o !== 6'd59 || load_o !== 1'b0) begin failures++; $display("FAIL sec_early got=%0d/%b exp=59/0", sec_o, load_o); end
    cyc();
    checks++; if (sec_o !== 6'd0 || load_o !== 1'b1) begin failures++; $display("FAIL sec_latency got=%0d/%b exp=0/1", sec_o, load_o); end
    inc_btn = 0;
    loads = 0;
    for (int i = 0; i < 12; i++) begin cyc(); loads += int'(load_o); end
    model_step(1, 1);
    checks++; if (loads !== 0) begin failures++; $display("FAIL sec_single_load extra=%0d exp=0", loads); end
    checks++; if (act() !== expv()) begin failures++; $display("FAIL sec_fields got=%h exp=%h", act(), expv()); end
  endtask

  task automatic test_hr_wrap();
    int loads;
    logic [63:0] mask;
    set_sw(4'b0001);
    press(0, 1, loads, mask);
    model_step(0, 1);
    checks++; if (hr_o !== 5'd23) begin failures++; $display("FAIL hr_wrap got=%0d exp=23", hr_o); end
    checks++; if (ms12_unused_hr !== 4'd11) begin failures++; $display("FAIL hr12_wrap got=%0d exp=11", ms12_unused_hr); end
    checks++; if (loads !== 1) begin failures++; $display("FAIL hr_loads got=%0d exp=1", loads); end
  endtask

  task automatic test_repeat();
    int loads;
    logic [63:0] mask;
    set_sw(4'b0010);
    for (int k = 0; k < 10; k++) begin press(1, 1, loads, mask); model_step(1, 1); end
    checks++; if (min_o !== 6'(m_min)) begin failures++; $display("FAIL min_setup got=%0d exp=%0d", min_o, m_min); end
    press(1, 30, loads, mask);
    model_step(1, steps_for(30));
    checks++; if (min_o !== 6'd17) begin failures++; $display("FAIL repeat_min got=%0d exp=17", min_o); end
    checks++; if (loads !== 7) begin failures++; $display("FAIL repeat_loads got=%0d exp=7", loads); end
    checks++; if (mask !== step_mask(30)) begin failures++; $display("FAIL repeat_timing got=%h exp=%h", mask, step_mask(30)); end
  endtask

  task automatic test_priority();
    int loads;
    logic [63:0] mask;
    set_sw(4'b1001);
    press(1, 1, loads, mask);
    model_step(1, 1);
    checks++; if (act() !== expv()) begin failures++; $display("FAIL priority got=%h exp=%h", act(), expv()); end
    inc_btn = 1;
    dec_btn = 1;
    loads = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) begin inc_btn = 0; dec_btn = 0; end
      cyc();
      loads += int'(load_o);
    end
    checks++; if (loads !== 0) begin failures++; $display("FAIL both_btn_loads got=%0d exp=0", loads); end
    checks++; if (act() !== expv()) begin failures++; $display("FAIL both_btn_fields got=%h exp=%h", act(), expv()); end
  endtask

  task automatic test_toggle();
    int loads = 0;
    logic [63:0] mask = '0;
    set_sw(4'b0010);
    toggle = 1;
    inc_btn = 1;
    clr_btn = 1;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) begin inc_btn = 0; clr_btn = 0; end
      cyc();
      loads += int'(load_o);
    end
    checks++; if (loads !== 0 || act() !== expv()) begin failures++; $display("FAIL toggle_hold loads=%0d got=%h exp=%h", loads, act(), expv()); end
    toggle = 0;
    repeat (4) cyc();
    inc_btn = 1;
    for (int i = 0; i < 36; i++) begin
      if (i == 18) toggle = 1;
      if (i == 25) inc_btn = 0;
      cyc();
      if (load_o) mask[i] = 1'b1;
    end
    toggle = 0;
    repeat (4) cyc();
    model_step(1, 3);
    checks++; if (mask !== step_mask(17)) begin failures++; $display("FAIL toggle_stop got=%h exp=%h", mask, step_mask(17)); end
    checks++; if (act() !== expv()) begin failures++; $display("FAIL toggle_fields got=%h exp=%h", act(), expv()); end
  endtask

  task automatic test_clear();
    int loads;
    logic [63:0] mask;
    for (int r = 0; r < 3; r++) begin
      loads = 0;
      mask = '0;
      set_sw(4'b0010);
      clr_btn = 1;
      if (r == 2) inc_btn = 1;
      for (int i = 0; i < 14; i++) begin
        if (i == 3) begin clr_btn = 0; inc_btn = 0; end
        cyc();
        if (load_o) begin loads++; mask[i] = 1'b1; end
      end
      model_zero();
      checks++; if (act() !== expv()) begin failures++; $display("FAIL clear_%0d got=%h exp=%h", r, act(), expv()); end
      checks++; if (mask !== 64'd4) begin failures++; $display("FAIL clear_load_%0d got=%h exp=4", r, mask); end
    end
  endtask

  task automatic test_reset_mid();
    int loads = 0;
    logic [63:0] mask;
    set_sw(4'b0010);
    inc_btn = 1;
    repeat (16) cyc();
    rst = 1;
    #2;
    checks++; if (act() !== 31'd0 || load_o !== 1'b0) begin failures++; $display("FAIL async_reset got=%h/%b exp=0/0", act(), load_o); end
    repeat (3) cyc();
    rst = 0;
    model_zero();
    for (int i = 0; i < 20; i++) begin cyc(); loads += int'(load_o); end
    inc_btn = 0;
    repeat (6) cyc();
    checks++; if (loads !== 0 || act() !== expv()) begin failures++; $display("FAIL held_through_reset loads=%0d got=%h exp=%h", loads, act(), expv()); end
    press(1, 1, loads, mask);
    model_step(1, 1);
    checks++; if (act() !== expv()) begin failures++; $display("FAIL repress_after_reset got=%h exp=%h", act(), expv()); end
  endtask

  task automatic test_random();
    int loads, h, exp_loads;
    bit up;
    logic [63:0] mask;
    for (int t = 0; t < 40; t++) begin
      set_sw(4'($urandom_range(0, 15)));
      up = 1'($urandom_range(0, 1));
      h = $urandom_range(1, 30);
      press(up, h, loads, mask);
      exp_loads = any_sw() ? steps_for(h) : 0;
      model_step(up, steps_for(h));
      checks++; if (loads !== exp_loads) begin failures++; $display("FAIL rand_loads_%0d got=%0d exp=%0d", t, loads, exp_loads); end
      checks++; if (act() !== expv()) begin failures++; $display("FAIL rand_fields_%0d got=%h exp=%h", t, act(), expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_sec_wrap();
    test_hr_wrap();
    test_repeat();
    test_priority();
    test_toggle();
    test_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
